// File: rtl/mem_bus_pkg.sv
// Shared definitions for the A2/D2/C2 memory bus controller.
//   cmd_e      : two-bit C2 command encoding
//   state_e    : controller sequencing states
//   port_vec_t : one bit per requester (bit 0 = fetch, bit 1 = load/store)
//   ADDR_W, DATA_W : bus widths
package mem_bus_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_ACK   = 2'd1,
        CMD_READ  = 2'd2,
        CMD_WRITE = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef logic [1:0] port_vec_t;

endpackage

// File: rtl/mem_bus_ctrl_rr_arb2.sv
// Two-way round-robin picker, purely combinational.
//   i_req        : request vector, bit n = port n
//   i_last_grant : port that owned the previous transaction
//   o_grant      : one-hot grant, all zero when nobody requests
// A lone requester always wins; on contention the port that did not
// go last wins, so neither port can starve the other.
module rr_arb2
    import mem_bus_pkg::*;
(
    input  port_vec_t i_req,
    input  logic      i_last_grant,
    output port_vec_t o_grant
);

    always_comb begin
        // NOTE: default assignment first, so every path assigns o_grant and no latch is inferred.
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Two-requester controller for the shared A2/D2/C2 memory bus.
// Port 0 (fetch) and port 1 (load/store) are arbitrated round-robin; the
// winner's command is issued for one cycle, the bus is released, and the
// controller waits for C2=ACK (or a timeout) before pulsing ack on the
// owning port. One transaction is outstanding at a time.
//   i_clk, i_rst           : clock, asynchronous active-high reset
//   i_req*/i_we*/i_addr*/i_wdata* : per-port request, level, held until ack
//   o_ack*/o_err*          : one-cycle completion pulse, err=1 on timeout
//   o_rdata*               : read data, held until that port's next ack
//   o_busy                 : a transaction is in flight
//   o_a2                   : memory address, held through the transaction
//   io_d2, io_c2           : bidirectional data/command, driven only in ISSUE
module mem_bus_ctrl #(
    parameter int ADDR_W  = mem_bus_pkg::ADDR_W,
    parameter int DATA_W  = mem_bus_pkg::DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    output logic              o_err0,
    output logic              o_err1,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_a2,
    inout  wire  [DATA_W-1:0] io_d2,
    inout  wire  [1:0]        io_c2
);

    import mem_bus_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            r_state;
    logic              r_owner;
    logic              r_we;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_a2;
    logic [DATA_W-1:0] r_d2_q;
    cmd_e              r_c2_q;
    logic              r_c2_oe;
    logic              r_d2_oe;
    logic              r_busy;
    logic [1:0]        r_ack;
    logic [1:0]        r_err;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    port_vec_t         w_grant;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_mem_ack;

    rr_arb2 u_arb (
        .i_req        ({i_req1, i_req0}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // Request fields of whichever port the arbiter picks this cycle.
    assign w_sel_we    = w_grant[1] ? i_we1    : i_we0;
    assign w_sel_addr  = w_grant[1] ? i_addr1  : i_addr0;
    assign w_sel_wdata = w_grant[1] ? i_wdata1 : i_wdata0;

    // Only meaningful in WAIT, when the controller has released C2.
    assign w_mem_ack = (io_c2 == CMD_ACK);

    // Bus drivers come straight from flops: no input-to-pad combinational path.
    assign io_c2 = r_c2_oe ? r_c2_q : 2'bzz;
    assign io_d2 = r_d2_oe ? r_d2_q : {DATA_W{1'bz}};

    assign o_a2     = r_a2;
    assign o_busy   = r_busy;
    assign o_ack0   = r_ack[0];
    assign o_ack1   = r_ack[1];
    assign o_err0   = r_err[0];
    assign o_err1   = r_err[1];
    assign o_rdata0 = r_rdata0;
    assign o_rdata1 = r_rdata1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_a2         <= '0;
            r_d2_q       <= '0;
            r_c2_q       <= CMD_NOP;
            r_c2_oe      <= 1'b0;
            r_d2_oe      <= 1'b0;
            r_busy       <= 1'b0;
            r_ack        <= 2'b00;
            r_err        <= 2'b00;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            // ack/err are single-cycle pulses; only the WAIT exit raises them.
            r_ack <= 2'b00;
            r_err <= 2'b00;

            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_owner <= w_grant[1];
                        r_we    <= w_sel_we;
                        r_a2    <= w_sel_addr;
                        r_d2_q  <= w_sel_wdata;
                        r_c2_q  <= w_sel_we ? CMD_WRITE : CMD_READ;
                        r_c2_oe <= 1'b1;
                        r_d2_oe <= w_sel_we;
                        r_busy  <= 1'b1;
                        r_state <= ISSUE;
                    end
                end

                ISSUE: begin
                    r_c2_oe <= 1'b0;
                    r_d2_oe <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end

                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // ACK is tested first so it beats a timeout landing on the same cycle.
                    if (w_mem_ack) begin
                        r_ack[r_owner] <= 1'b1;
                        if (!r_we) begin
                            if (r_owner) r_rdata1 <= io_d2;
                            else         r_rdata0 <= io_d2;
                        end
                        r_state <= DONE;
                    end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                        r_ack[r_owner] <= 1'b1;
                        r_err[r_owner] <= 1'b1;
                        if (r_owner) r_rdata1 <= '0;
                        else         r_rdata0 <= '0;
                        r_state <= DONE;
                    end
                end

                DONE: begin
                    r_last_grant <= r_owner;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl. Stimulus pushes the expected
// transaction (port, command, memory behaviour) onto a scoreboard queue;
// the negedge monitor pops it when the DUT issues on the bus, plays the
// memory, and checks status/rdata every cycle against the model.
module tb_mem_bus_ctrl;

    localparam int TIMEOUT = 255;
    localparam logic [1:0] C_ACK   = 2'd1;
    localparam logic [1:0] C_READ  = 2'd2;
    localparam logic [1:0] C_WRITE = 2'd3;

    typedef struct {
        bit          port;
        bit          we;
        logic [17:0] addr;
        logic [15:0] wdata;
        int          delay;   // memory drives ACK in WAIT cycle number 'delay'; 0 = never
        logic [15:0] mdata;
    } txn_t;

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [17:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        o_ack0, o_ack1, o_err0, o_err1, o_busy;
    logic [15:0] o_rdata0, o_rdata1;
    logic [17:0] o_a2;
    wire  [15:0] d2;
    wire  [1:0]  c2;

    int          n_checks;
    int          n_errors;
    int          cyc;

    txn_t        sb[$];
    txn_t        cur;
    bit          have_cur;
    bit          cur_err;
    int          cur_lat;
    int          grant_cyc;
    bit          post_issue;
    logic [15:0] rd_mdl [2];
    bit          lg;
    int          rem [2];

    int          mem_cnt;
    bit          mem_drv;
    logic [15:0] mem_data;

    assign c2 = mem_drv ? C_ACK : 2'bzz;
    assign d2 = mem_drv ? mem_data : 16'hzzzz;

    mem_bus_ctrl #(.ADDR_W(18), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req0   (req0),
        .i_req1   (req1),
        .i_we0    (we0),
        .i_we1    (we1),
        .i_addr0  (addr0),
        .i_addr1  (addr1),
        .i_wdata0 (wdata0),
        .i_wdata1 (wdata1),
        .o_ack0   (o_ack0),
        .o_ack1   (o_ack1),
        .o_rdata0 (o_rdata0),
        .o_rdata1 (o_rdata1),
        .o_err0   (o_err0),
        .o_err1   (o_err1),
        .o_busy   (o_busy),
        .o_a2     (o_a2),
        .io_d2    (d2),
        .io_c2    (c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory model and per-cycle monitor.
    always @(negedge clk) begin
        logic [1:0]  c2_s;
        logic [15:0] d2_s;
        logic [4:0]  exp_st;
        bit          due;
        c2_s = c2;
        d2_s = d2;

        // A response lasts one cycle; the countdown runs even through reset.
        mem_drv = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) mem_drv = 1'b1;
        end

        if (!rst) begin
            if (post_issue) begin
                check("c2_released", dut.r_c2_oe, 0);
                check("d2_released", dut.r_d2_oe, 0);
                post_issue = 1'b0;
            end
            if (c2_s == C_READ || c2_s == C_WRITE) begin
                if (sb.size() == 0) begin
                    check("unexpected_issue", c2_s, 0);
                end else begin
                    cur       = sb.pop_front();
                    have_cur  = 1'b1;
                    grant_cyc = cyc;
                    cur_err   = !(cur.delay >= 1 && cur.delay <= TIMEOUT + 1);
                    cur_lat   = cur_err ? TIMEOUT + 2 : cur.delay + 1;
                    check("issue_cmd", c2_s, cur.we ? C_WRITE : C_READ);
                    check("issue_d2_oe", dut.r_d2_oe, cur.we);
                    if (cur.we) check("issue_d2", d2_s, cur.wdata);
                    mem_cnt    = cur.delay;
                    mem_data   = cur.mdata;
                    post_issue = 1'b1;
                end
            end
            if (have_cur) check("a2", o_a2, cur.addr);

            due    = have_cur && (cyc - grant_cyc == cur_lat);
            exp_st = {have_cur, due && cur.port, due && !cur.port,
                      due && cur.port && cur_err, due && !cur.port && cur_err};
            check("status{busy,ack1,ack0,err1,err0}",
                  {o_busy, o_ack1, o_ack0, o_err1, o_err0}, exp_st);
            if (due) begin
                if (cur_err)      rd_mdl[cur.port] = 16'h0;
                else if (!cur.we) rd_mdl[cur.port] = cur.mdata;
                lg       = cur.port;
                have_cur = 1'b0;
            end
            check("rdata0", o_rdata0, rd_mdl[0]);
            check("rdata1", o_rdata1, rd_mdl[1]);
        end
    end

    task automatic push(input bit p, input bit we, input logic [17:0] a,
                        input logic [15:0] wd, input int d, input logic [15:0] md);
        txn_t t;
        t.port = p; t.we = we; t.addr = a; t.wdata = wd; t.delay = d; t.mdata = md;
        sb.push_back(t);
    endtask

    // Raise a request that stays high for n acks on that port.
    task automatic drive(input bit p, input bit we, input logic [17:0] a,
                         input logic [15:0] wd, input int n);
        rem[p] = n;
        if (p) begin we1 = we; addr1 = a; wdata1 = wd; req1 = 1'b1; end
        else   begin we0 = we; addr0 = a; wdata0 = wd; req0 = 1'b1; end
    endtask

    task automatic wait_acks(input int n, input int budget);
        int seen = 0;
        int t = 0;
        while (seen < n && t < budget) begin
            @(negedge clk);
            t++;
            if (o_ack0) begin
                seen++;
                if (rem[0] > 0) begin rem[0]--; if (rem[0] == 0) req0 = 1'b0; end
            end
            if (o_ack1) begin
                seen++;
                if (rem[1] > 0) begin rem[1]--; if (rem[1] == 0) req1 = 1'b0; end
            end
        end
        check("acks_seen", seen, n);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_busy(input int budget);
        int t = 0;
        while (!o_busy && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("busy_seen", o_busy, 1);
    endtask

    initial begin
        bit first;
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        n_checks = 0; n_errors = 0; cyc = 0;
        have_cur = 0; post_issue = 0; lg = 1'b1;
        rd_mdl = '{16'h0, 16'h0};
        rem = '{0, 0};
        mem_cnt = 0; mem_drv = 0; mem_data = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_ack", {o_ack1, o_ack0}, 0);
        check("rst_err", {o_err1, o_err0}, 0);
        check("rst_rdata0", o_rdata0, 0);
        check("rst_rdata1", o_rdata1, 0);
        check("rst_a2", o_a2, 0);
        check("rst_c2_oe", dut.r_c2_oe, 0);
        check("rst_d2_oe", dut.r_d2_oe, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single read: ACK+BEEF 101 cycles after the grant edge, ack 102 after it.
        push(0, 0, 18'h00010, 16'h0, 101, 16'hBEEF);
        drive(0, 0, 18'h00010, 16'h0, 1);
        wait_acks(1, 200);

        // Write at the top address: command/data checked in ISSUE, released after.
        push(1, 1, 18'h3FFFF, 16'h1234, 5, 16'hFFFF);
        drive(1, 1, 18'h3FFFF, 16'h1234, 1);
        wait_acks(1, 50);

        // Contention: both held for two transactions each, grants must alternate.
        first = ~lg;
        for (int i = 0; i < 4; i++) begin
            bit p;
            p = (i % 2 == 0) ? first : ~first;
            push(p, p, p ? 18'h00200 : 18'h00100, p ? 16'h5555 : 16'h0, 3 + i, 16'hC000 + 16'(i));
        end
        drive(0, 0, 18'h00100, 16'h0, 2);
        drive(1, 1, 18'h00200, 16'h5555, 2);
        wait_acks(4, 200);

        // Silent memory: error completion with rdata cleared, then a normal read.
        push(0, 0, 18'h0ABCD, 16'h0, 0, 16'h0);
        drive(0, 0, 18'h0ABCD, 16'h0, 1);
        wait_acks(1, 400);
        push(0, 0, 18'h00020, 16'h0, 4, 16'h5A5A);
        drive(0, 0, 18'h00020, 16'h0, 1);
        wait_acks(1, 50);

        // ACK on the last counted cycle wins; one cycle later it is too late.
        push(1, 0, 18'h1F00F, 16'h0, TIMEOUT + 1, 16'hD00D);
        drive(1, 0, 18'h1F00F, 16'h0, 1);
        wait_acks(1, 400);
        push(0, 0, 18'h00030, 16'h0, TIMEOUT + 2, 16'hBAD0);
        drive(0, 0, 18'h00030, 16'h0, 1);
        wait_acks(1, 400);

        // Request withdrawn during WAIT: the transaction still completes once.
        push(1, 0, 18'h00040, 16'h0, 20, 16'h4444);
        drive(1, 0, 18'h00040, 16'h0, 1);
        repeat (5) @(negedge clk);
        req1 = 1'b0;
        rem[1] = 0;
        wait_acks(1, 100);

        // Reset 20 cycles into the transaction; the memory still answers later.
        push(0, 0, 18'h2AAAA, 16'h0, 30, 16'h7777);
        drive(0, 0, 18'h2AAAA, 16'h0, 1);
        wait_busy(10);
        repeat (20) @(negedge clk);
        #1;
        rst = 1'b1;
        have_cur = 1'b0;
        post_issue = 1'b0;
        rd_mdl = '{16'h0, 16'h0};
        lg = 1'b1;
        #1;
        check("midrst_busy", o_busy, 0);
        check("midrst_c2_oe", dut.r_c2_oe, 0);
        check("midrst_d2_oe", dut.r_d2_oe, 0);
        check("midrst_ack", {o_ack1, o_ack0}, 0);
        check("midrst_a2", o_a2, 0);
        check("midrst_rdata1", o_rdata1, 0);
        req0 = 1'b0;
        rem[0] = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);

        // After reset last_grant is 1, so port 0 wins a simultaneous request.
        push(0, 0, 18'h00050, 16'h0, 2, 16'h1111);
        push(1, 0, 18'h00060, 16'h0, 2, 16'h2222);
        drive(0, 0, 18'h00050, 16'h0, 1);
        drive(1, 0, 18'h00060, 16'h0, 1);
        wait_acks(2, 100);

        check("sb_drained", sb.size(), 0);
        check("end_busy", o_busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
